// File: rtl/accel_rd_sched_pkg.sv
// Shared definitions for the accel_rd_sched slice: controller state encoding,
// default flush length and a small index helper.
package accel_rd_sched_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    localparam int DRAIN_CYCLES_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ISSUE  = ST_ISSUE,
        STREAM = ST_STREAM,
        FLUSH  = ST_FLUSH
    } sched_state_e;

    // Next round-robin start position after index idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/accel_rr_arb.sv
// Combinational round-robin search: first set request at or above ptr_i,
// otherwise the lowest set request (wrap-around).
module accel_rr_arb
    import accel_rd_sched_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int IW         = $clog2(PORT_COUNT)
) (
    input  logic [PORT_COUNT-1:0] req_i,
    input  logic [IW-1:0]         ptr_i,
    output logic                  valid_o,
    output logic [IW-1:0]         idx_o
);

    logic          hi_found;
    logic [IW-1:0] hi_idx;
    logic          lo_found;
    logic [IW-1:0] lo_idx;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = PORT_COUNT - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(j);
                if (IW'(j) >= ptr_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(j);
                end
            end
        end
        valid_o = lo_found;
        idx_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/accel_rd_sched.sv
// Round-robin descriptor scheduler sharing one read-DMA engine among PORT_COUNT
// requesters. Optional stall watchdog: define ACCEL_RD_SCHED_TIMEOUT_EN.
module accel_rd_sched
    import accel_rd_sched_pkg::*;
#(
    parameter int PORT_COUNT     = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 18,
    parameter int LEN_WIDTH      = 14,
    parameter int MASK_BITS      = $clog2(DATA_WIDTH/8),
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IW             = $clog2(PORT_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst,
    // All handshakes: a transfer happens on a cycle where valid and ready are
    // both 1; a source holds valid and payload stable until that cycle.
    input  logic [PORT_COUNT*ADDR_WIDTH-1:0] s_desc_addr,
    input  logic [PORT_COUNT*LEN_WIDTH-1:0]  s_desc_len,
    input  logic [PORT_COUNT-1:0]            s_desc_valid,
    output logic [PORT_COUNT-1:0]            s_desc_ready,
    input  logic [PORT_COUNT-1:0]            s_stop,
    output logic [ADDR_WIDTH-1:0]            dma_desc_addr,
    output logic [LEN_WIDTH-1:0]             dma_desc_len,
    output logic                             dma_desc_valid,
    input  logic                             dma_desc_ready,
    output logic                             dma_stop,
    input  logic [DATA_WIDTH-1:0]            dma_axis_tdata,
    input  logic [MASK_BITS-1:0]             dma_axis_tempty,
    input  logic                             dma_axis_tfirst,
    input  logic                             dma_axis_tlast,
    input  logic                             dma_axis_tvalid,
    output logic                             dma_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [MASK_BITS-1:0]             m_axis_tempty,
    output logic                             m_axis_tfirst,
    output logic                             m_axis_tlast,
    output logic [PORT_COUNT-1:0]            m_axis_tvalid,
    input  logic [PORT_COUNT-1:0]            m_axis_tready,
    output logic [IW-1:0]                    grant_id,
    output logic                             busy,
    output logic                             timeout_err,
    output logic [1:0]                       dbg_state
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DCW-1:0]        drain_q, drain_d;
    logic                  stop_q, stop_d;

    logic                  arb_valid;
    logic [IW-1:0]         arb_idx;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic                  fwd_active;
    logic                  beat;
    logic                  issue_entry;
    logic                  tmo_hit;
    logic                  abort_req;

    accel_rr_arb #(
        .PORT_COUNT (PORT_COUNT),
        .IW         (IW)
    ) u_arb (
        .req_i   (s_desc_valid),
        .ptr_i   (rr_ptr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    assign req_addr    = s_desc_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_len     = s_desc_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
    assign fwd_active  = (state_q == ISSUE) || (state_q == STREAM);
    assign beat        = fwd_active && dma_axis_tvalid && m_axis_tready[grant_q];
    assign issue_entry = (state_q == IDLE) && arb_valid && (req_len != '0);
    assign abort_req   = fwd_active && (s_stop[grant_q] || tmo_hit);

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        addr_d          = addr_q;
        len_d           = len_q;
        drain_d         = drain_q;
        stop_d          = 1'b0;
        s_desc_ready    = '0;
        dma_desc_valid  = 1'b0;
        dma_axis_tready = 1'b0;
        m_axis_tvalid   = '0;

        if (fwd_active) begin
            m_axis_tvalid[grant_q] = dma_axis_tvalid;
            dma_axis_tready        = m_axis_tready[grant_q];
        end

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    s_desc_ready[arb_idx] = !rst;
                    grant_d  = arb_idx;
                    addr_d   = req_addr;
                    len_d    = req_len;
                    rr_ptr_d = IW'(rr_next(int'(arb_idx), PORT_COUNT));
                    // Zero-length descriptors are consumed without touching the engine.
                    if (req_len != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                dma_desc_valid = 1'b1;
                if (abort_req) begin
                    state_d = FLUSH;
                    stop_d  = 1'b1;
                    drain_d = DRAIN_LOAD;
                end else if (dma_desc_ready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // A completing last beat wins over a same-cycle abort request.
                if (beat && dma_axis_tlast) begin
                    state_d = IDLE;
                end else if (abort_req) begin
                    state_d = FLUSH;
                    stop_d  = 1'b1;
                    drain_d = DRAIN_LOAD;
                end
            end
            FLUSH: begin
                dma_axis_tready = 1'b1;
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            drain_q  <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            drain_q  <= drain_d;
            stop_q   <= stop_d;
        end
    end

`ifdef ACCEL_RD_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_err_q;

    // A requester holding off the stream is not an engine stall, so it freezes the count.
    always_comb begin
        tmo_d   = tmo_q;
        tmo_hit = 1'b0;
        if (issue_entry) begin
            tmo_d = '0;
        end else if (fwd_active) begin
            if (beat) begin
                tmo_d = '0;
            end else if (m_axis_tready[grant_q]) begin
                tmo_d   = tmo_q + 1'b1;
                tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign dma_desc_addr = addr_q;
    assign dma_desc_len  = len_q;
    assign dma_stop      = stop_q;
    assign m_axis_tdata  = dma_axis_tdata;
    assign m_axis_tempty = dma_axis_tempty;
    assign m_axis_tfirst = dma_axis_tfirst;
    assign m_axis_tlast  = dma_axis_tlast;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: doc/accel_rd_sched.md
# accel_rd_sched

Round-robin descriptor scheduler that shares one `single_accel_rd_dma` engine among PORT_COUNT accelerator requesters. It sits between the per-accelerator descriptor/stream ports and the DMA engine's descriptor and `m_axis` interfaces. It serializes transfers, routes the DMA output stream to the owning requester, and sequences per-requester aborts through the engine's `accel_stop`.

## Interface
Parameters:
- PORT_COUNT, 4, number of requesters (≥2)
- DATA_WIDTH, 128, DMA output data width
- ADDR_WIDTH, 18, descriptor byte address width
- LEN_WIDTH, 14, descriptor byte length width
- MASK_BITS, $clog2(DATA_WIDTH/8), width of tempty
- DRAIN_CYCLES, 6, cycles spent discarding engine output after an abort
- TIMEOUT_CYCLES, 4096, stall limit (used only with the timeout feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- s_desc_addr  in  PORT_COUNT*ADDR_WIDTH  per-port descriptor address
- s_desc_len  in  PORT_COUNT*LEN_WIDTH  per-port descriptor length in bytes
- s_desc_valid  in  PORT_COUNT  per-port descriptor valid
- s_desc_ready  out  PORT_COUNT  per-port accept; one-hot or zero
- s_stop  in  PORT_COUNT  per-port abort request
- dma_desc_addr  out  ADDR_WIDTH  to engine
- dma_desc_len  out  LEN_WIDTH  to engine
- dma_desc_valid  out  1  to engine
- dma_desc_ready  in  1  from engine
- dma_stop  out  1  engine abort pulse
- dma_axis_tdata/tempty/tfirst/tlast  in  DATA_WIDTH/MASK_BITS/1/1  engine output stream
- dma_axis_tvalid  in  1;  dma_axis_tready  out  1
- m_axis_tdata/tempty/tfirst/tlast  out  DATA_WIDTH/MASK_BITS/1/1  broadcast to all ports
- m_axis_tvalid  out  PORT_COUNT  per-port valid, one-hot or zero
- m_axis_tready  in  PORT_COUNT  per-port ready
- grant_id  out  $clog2(PORT_COUNT)  current owner
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on watchdog abort

## Operation
- The controller has four states: IDLE, ISSUE, STREAM and FLUSH.
- **IDLE:**
  - The arbiter searches s_desc_valid starting at rr_ptr, wrapping modulo PORT_COUNT, and picks the first set port g.
  - s_desc_ready[g]=1 combinationally, in the same cycle.
  - The descriptor is latched and grant_id←g.
  - If len≠0: rr_ptr←g+1 (wrapping) and the next state is ISSUE.
  - If len==0: the descriptor is consumed and discarded, rr_ptr←g+1, and the state stays IDLE.
- **ISSUE:**
  - dma_desc_valid=1 with the latched addr/len.
  - On dma_desc_ready, go to STREAM.
- **STREAM:**
  - m_axis_tvalid[grant_id]=dma_axis_tvalid.
  - dma_axis_tready=m_axis_tready[grant_id].
  - All other m_axis_tvalid bits are 0.
  - On a handshake with dma_axis_tlast=1, return to IDLE.
  - Output forwarding is also active in ISSUE; the engine cannot produce data before accepting the descriptor.
- **Abort:**
  - Trigger: s_stop[grant_id]=1 in ISSUE or STREAM.
  - dma_stop pulses for 1 cycle.
  - dma_desc_valid drops and the state moves to FLUSH.
  - s_stop on non-granted ports is ignored.
- **FLUSH:**
  - dma_axis_tready=1 and all m_axis_tvalid=0; the engine output is discarded.
  - After DRAIN_CYCLES cycles, return to IDLE.
- The m_axis data and sideband signals are wired directly from dma_axis_*.

## Timing
- Reset: state=IDLE and rr_ptr=0, so port 0 wins first.
- Every output is 0 in reset: s_desc_ready, dma_desc_valid, dma_stop, m_axis_tvalid, grant_id, busy, timeout_err.
- Latency: a descriptor accepted at cycle T drives dma_desc_valid at T+1.
- Back-to-back transfers: the cycle after the last-beat handshake is IDLE, so the next grant can occur there.
- dma_desc_valid is held stable, with stable addr/len, until dma_desc_ready.
- Simultaneous last-beat handshake and s_stop[grant_id] in the same cycle: the transfer completes normally, with no dma_stop and no FLUSH.
- Reset mid-transfer: the state returns to IDLE immediately. The engine shares rst and is cleared in the same cycle.
- grant_id is held from acceptance until the state returns to IDLE.

## Configuration
- `ACCEL_RD_SCHED_TIMEOUT_EN` defined:
  - A counter clears on every dma_axis handshake and on entry to ISSUE, and increments each cycle in ISSUE/STREAM without a handshake.
  - While the granted port stalls with m_axis_tready=0, the counter is held rather than incremented.
  - When the counter reaches TIMEOUT_CYCLES, the abort path runs (dma_stop pulse, then FLUSH) and timeout_err pulses for 1 cycle.
- Macro undefined: no counter is built and timeout_err is tied to 0.

## Structure
- Package `accel_rd_sched_pkg` holds:
  - the state encoding localparams (IDLE=0, ISSUE=1, STREAM=2, FLUSH=3);
  - the DRAIN_CYCLES default.
- One sub-module, `accel_rr_arb`, provides the parameterized round-robin search. It takes the request vector and rr_ptr and returns a valid flag plus the winner index.

## Test plan
- Ports 0 and 2 valid at the same time after reset; each has a 64 B descriptor at addr 0x100 → port 0 granted first and receives 4 beats with tfirst on beat 0 and tlast on beat 3; port 2 is granted next.
- All 4 ports continuously valid, 3 descriptors each → grant order 0,1,2,3,0,1,2,3,… with no port starved.
- Port 1 descriptor with len=0 → s_desc_ready[1] pulses, dma_desc_valid never rises, busy stays 0.
- s_stop[grant_id] asserted mid-STREAM of a 1024 B transfer → dma_stop pulses for 1 cycle, no further m_axis_tvalid, return to IDLE after 6 cycles, next request served correctly.
- Granted port holds m_axis_tready=0 for 50 cycles → tvalid stays asserted with data stable and no timeout (timeout build: TIMEOUT_CYCLES=16).
- Timeout build with the engine stalled (dma_desc_ready=0 for 20 cycles) → timeout_err pulse after 16 cycles, followed by a dma_stop pulse and FLUSH.
